axi_credit_gate: RTL and testbench

Zero-latency AXI4 pass-through between an application wrapper's virtual-memory master port and the shell's memory interconnect. It caps outstanding read and write bursts per application, orders W data behind its AW, and supports a drain/quiesce handshake for safe app reconfiguration. Optional beat counters provide per-app bandwidth statistics.

---
 rtl/axi_credit_gate.sv | 186 ++++++++++++++++++
 tb/tb_axi_credit_gate.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_credit_gate.sv
// Zero-latency AXI4 pass-through that caps outstanding read and write bursts, holds W behind its AW, and supports drain.
// Optional beat statistics are compiled in when AXI_CREDIT_GATE_STATS_EN is defined.
module axi_credit_gate #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int MAX_RD = 32,
  parameter int MAX_WR = 32
) (
  input  logic                clk,
  input  logic                rst,
  // read address
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  // read data
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  // write address
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic                s_awvalid,
  output logic                s_awready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  // write data
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  // write response
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  // control and status
  input  logic                drain_req,
  output logic                drain_idle,
  output logic [7:0]          rd_outstanding,
  output logic [7:0]          wr_outstanding,
  output logic [31:0]         rd_beats,
  output logic [31:0]         wr_beats
);

  localparam logic [7:0] RD_LIM = 8'(MAX_RD);
  localparam logic [7:0] WR_LIM = 8'(MAX_WR);

  logic [7:0] rd_cnt, wr_cnt, w_cnt;
  logic       ar_ok, aw_ok, w_ok;
  logic       ar_hs, aw_hs, r_hs, r_done, w_hs, w_done, b_hs;

  // Retire and issue in the same cycle cancel; a retire at zero saturates.
  function automatic logic [7:0] step_cnt(input logic [7:0] c, input logic inc, input logic dec);
    logic [7:0] n;
    n = c;
    if (inc && !dec)
      n = c + 8'd1;
    else if (dec && !inc && c != 8'd0)
      n = c - 8'd1;
    return n;
  endfunction

  assign ar_ok = (rd_cnt < RD_LIM) && !drain_req;
  assign aw_ok = (wr_cnt < WR_LIM) && !drain_req;
  assign w_ok  = (w_cnt != 8'd0);

  assign m_arid    = s_arid;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arvalid = s_arvalid & ar_ok;
  assign s_arready = m_arready & ar_ok;

  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;

  assign m_awid    = s_awid;
  assign m_awaddr  = s_awaddr;
  assign m_awlen   = s_awlen;
  assign m_awsize  = s_awsize;
  assign m_awvalid = s_awvalid & aw_ok;
  assign s_awready = m_awready & aw_ok;

  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = s_wlast;
  assign m_wvalid = s_wvalid & w_ok;
  assign s_wready = m_wready & w_ok;

  assign s_bid    = m_bid;
  assign s_bresp  = m_bresp;
  assign s_bvalid = m_bvalid;
  assign m_bready = s_bready;

  assign ar_hs  = m_arvalid & m_arready;
  assign aw_hs  = m_awvalid & m_awready;
  assign r_hs   = m_rvalid & m_rready;
  assign r_done = r_hs & m_rlast;
  assign w_hs   = m_wvalid & m_wready;
  assign w_done = w_hs & s_wlast;
  assign b_hs   = m_bvalid & m_bready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= 8'd0;
      wr_cnt <= 8'd0;
      w_cnt  <= 8'd0;
    end else begin
      rd_cnt <= step_cnt(rd_cnt, ar_hs, r_done);
      wr_cnt <= step_cnt(wr_cnt, aw_hs, b_hs);
      w_cnt  <= step_cnt(w_cnt, aw_hs, w_done);
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;
  assign drain_idle     = drain_req && (rd_cnt == 8'd0) && (wr_cnt == 8'd0) && (w_cnt == 8'd0);

`ifdef AXI_CREDIT_GATE_STATS_EN
  logic [31:0] rd_beat_q, wr_beat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_beat_q <= 32'd0;
      wr_beat_q <= 32'd0;
    end else begin
      rd_beat_q <= rd_beat_q + 32'(r_hs);
      wr_beat_q <= wr_beat_q + 32'(w_hs);
    end
  end

  assign rd_beats = rd_beat_q;
  assign wr_beats = wr_beat_q;
`else
  assign rd_beats = 32'd0;
  assign wr_beats = 32'd0;
`endif

  // Responses with nothing outstanding are protocol errors; the counters saturate at zero.
  rd_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(r_done && !ar_hs && rd_cnt == 8'd0))
    else $warning("axi_credit_gate: R last with no outstanding read");
  wr_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(b_hs && !aw_hs && wr_cnt == 8'd0))
    else $warning("axi_credit_gate: B with no outstanding write");

endmodule

// File: tb/tb_axi_credit_gate.sv
// Bench for axi_credit_gate: reset-time gate table, directed corner sequences, randomized run against a counting model.
module tb_axi_credit_gate;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MAX_RD = 4, MAX_WR = 4;
`ifdef AXI_CREDIT_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [ID_W-1:0] s_arid, m_arid, s_rid, m_rid, s_awid, m_awid, s_bid, m_bid;
  logic [ADDR_W-1:0] s_araddr, m_araddr, s_awaddr, m_awaddr;
  logic [7:0] s_arlen, m_arlen, s_awlen, m_awlen;
  logic [2:0] s_arsize, m_arsize, s_awsize, m_awsize;
  logic s_arvalid, s_arready, m_arvalid, m_arready;
  logic [DATA_W-1:0] s_rdata, m_rdata, s_wdata, m_wdata;
  logic [1:0] s_rresp, m_rresp, s_bresp, m_bresp;
  logic s_rlast, m_rlast, s_rvalid, m_rvalid, s_rready, m_rready;
  logic s_awvalid, s_awready, m_awvalid, m_awready;
  logic [DATA_W/8-1:0] s_wstrb, m_wstrb;
  logic s_wlast, m_wlast, s_wvalid, m_wvalid, s_wready, m_wready;
  logic s_bvalid, m_bvalid, s_bready, m_bready;
  logic drain_req, drain_idle;
  logic [7:0] rd_outstanding, wr_outstanding;
  logic [31:0] rd_beats, wr_beats;

  axi_credit_gate #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD), .MAX_WR(MAX_WR)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .drain_req(drain_req), .drain_idle(drain_idle),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  int n_chk = 0, n_pass = 0;
  int mdl_rd, mdl_wr, mdl_wp;
  logic [31:0] mdl_rb, mdl_wb;
  int n_ar, n_w;

  typedef struct {
    logic arv, arr, awv, awr, wv, wr, drn;
    logic e_marv, e_sarr, e_mawv, e_sawr, e_mwv, e_swr, e_idle;
  } vec_t;
  vec_t vecs[8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic idle();
    s_arvalid = 0; m_arready = 1; s_awvalid = 0; m_awready = 1;
    s_wvalid = 0; m_wready = 1; s_wlast = 0; m_rvalid = 0; m_rlast = 0; s_rready = 1;
    m_bvalid = 0; s_bready = 1; drain_req = 0;
  endtask

  task automatic randomize_payload();
    s_arid = ID_W'($urandom); s_araddr = $urandom; s_arlen = 8'($urandom); s_arsize = 3'($urandom);
    s_awid = ID_W'($urandom); s_awaddr = $urandom; s_awlen = 8'($urandom); s_awsize = 3'($urandom);
    m_rid = ID_W'($urandom); m_rdata = $urandom; m_rresp = 2'($urandom);
    s_wdata = $urandom; s_wstrb = 4'($urandom); m_bid = ID_W'($urandom); m_bresp = 2'($urandom);
  endtask

  function automatic void model_clear();
    mdl_rd = 0; mdl_wr = 0; mdl_wp = 0; mdl_rb = 0; mdl_wb = 0;
  endfunction

  function automatic void check_outputs();
    bit ar_ok, aw_ok, w_ok;
    ar_ok = (mdl_rd < MAX_RD) && !drain_req;
    aw_ok = (mdl_wr < MAX_WR) && !drain_req;
    w_ok  = mdl_wp > 0;
    chk("m_arvalid", m_arvalid, s_arvalid && ar_ok);
    chk("s_arready", s_arready, m_arready && ar_ok);
    chk("m_awvalid", m_awvalid, s_awvalid && aw_ok);
    chk("s_awready", s_awready, m_awready && aw_ok);
    chk("m_wvalid", m_wvalid, s_wvalid && w_ok);
    chk("s_wready", s_wready, m_wready && w_ok);
    chk("drain_idle", drain_idle, drain_req && mdl_rd == 0 && mdl_wr == 0 && mdl_wp == 0);
    chk("rd_outstanding", rd_outstanding, mdl_rd);
    chk("wr_outstanding", wr_outstanding, mdl_wr);
    chk("rd_beats", rd_beats, STATS ? mdl_rb : 32'd0);
    chk("wr_beats", wr_beats, STATS ? mdl_wb : 32'd0);
    chk("m_araddr", m_araddr, s_araddr);
    chk("s_rdata", s_rdata, m_rdata);
    chk("m_wdata", m_wdata, s_wdata);
    chk("s_bresp", s_bresp, m_bresp);
    chk("s_rvalid", s_rvalid, m_rvalid);
  endfunction

  // One clock: check outputs mid-cycle, then advance the model by the rules of the spec.
  task automatic cycle();
    bit ar_hs, aw_hs, w_hs, r_hs;
    @(negedge clk);
    check_outputs();
    n_ar += (m_arvalid && m_arready) ? 1 : 0;
    n_w  += (m_wvalid && m_wready) ? 1 : 0;
    ar_hs = s_arvalid && m_arready && (mdl_rd < MAX_RD) && !drain_req;
    aw_hs = s_awvalid && m_awready && (mdl_wr < MAX_WR) && !drain_req;
    w_hs  = s_wvalid && m_wready && (mdl_wp > 0);
    r_hs  = m_rvalid && s_rready;
    @(posedge clk);
    mdl_rd = mdl_rd + int'(ar_hs) - int'(r_hs && m_rlast);
    if (mdl_rd < 0) mdl_rd = 0;
    mdl_wr = mdl_wr + int'(aw_hs) - int'(m_bvalid && s_bready);
    if (mdl_wr < 0) mdl_wr = 0;
    mdl_wp = mdl_wp + int'(aw_hs) - int'(w_hs && s_wlast);
    mdl_rb = mdl_rb + 32'(r_hs);
    mdl_wb = mdl_wb + 32'(w_hs);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    model_clear();
    #1;
    chk("rst_rd_outstanding", rd_outstanding, 0);
    chk("rst_wr_outstanding", wr_outstanding, 0);
    chk("rst_rd_beats", rd_beats, 0);
    chk("rst_wr_beats", wr_beats, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    rst = 0;
    idle();
    randomize_payload();
    model_clear();
    //          arv arr awv awr wv wr drn | marv sarr mawv sawr mwv swr idle
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 1, 1, 1, 0,  0, 1, 0, 1, 0, 0, 0};
    vecs[4] = '{1, 1, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 1};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1};
    vecs[6] = '{0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      s_arvalid = vecs[i].arv; m_arready = vecs[i].arr; s_awvalid = vecs[i].awv; m_awready = vecs[i].awr;
      s_wvalid = vecs[i].wv; m_wready = vecs[i].wr; drain_req = vecs[i].drn;
      #1;
      chk($sformatf("tbl%0d_m_arvalid", i), m_arvalid, vecs[i].e_marv);
      chk($sformatf("tbl%0d_s_arready", i), s_arready, vecs[i].e_sarr);
      chk($sformatf("tbl%0d_m_awvalid", i), m_awvalid, vecs[i].e_mawv);
      chk($sformatf("tbl%0d_s_awready", i), s_awready, vecs[i].e_sawr);
      chk($sformatf("tbl%0d_m_wvalid", i), m_wvalid, vecs[i].e_mwv);
      chk($sformatf("tbl%0d_s_wready", i), s_wready, vecs[i].e_swr);
      chk($sformatf("tbl%0d_drain_idle", i), drain_idle, vecs[i].e_idle);
    end
    idle();
    @(posedge clk);
    #1 rst = 1;
    cycle();

    // Read cap: six requests, only four admitted while R is held off.
    s_arlen = 0; s_arvalid = 1; n_ar = 0;
    repeat (6) cycle();
    chk("ar_cap_handshakes", n_ar, 4);
    chk("ar_cap_outstanding", rd_outstanding, 4);
    chk("ar_cap_ready", s_arready, 0);
    m_rvalid = 1; m_rlast = 1;
    cycle();
    m_rvalid = 0; n_ar = 0;
    cycle();
    chk("ar_reopen_handshake", n_ar, 1);
    // Retire and issue together at MAX-1.
    s_arvalid = 0; m_rvalid = 1;
    cycle();
    s_arvalid = 1;
    cycle();
    s_arvalid = 0; m_rvalid = 0;
    chk("ar_simul_outstanding", rd_outstanding, 3);
    chk("ar_simul_gate_open", s_arready, 1);
    m_rvalid = 1;
    repeat (3) cycle();
    m_rvalid = 0; m_rlast = 0;
    chk("rd_drained", rd_outstanding, 0);

    // W held until the cycle after its AW.
    s_wvalid = 1; s_wlast = 0; n_w = 0;
    repeat (3) cycle();
    chk("w_before_aw", n_w, 0);
    s_awlen = 3; s_awvalid = 1;
    cycle();
    s_awvalid = 0;
    chk("w_during_aw", n_w, 0);
    for (int b = 0; b < 4; b++) begin
      s_wlast = (b == 3); s_wdata = $urandom;
      cycle();
    end
    chk("w_burst_beats", n_w, 4);
    s_wlast = 0;
    cycle();
    chk("w_closed_after_last", n_w, 4);
    s_wvalid = 0; m_bvalid = 1;
    cycle();
    m_bvalid = 0;

    // Drain with two writes outstanding.
    s_awlen = 0; s_awvalid = 1;
    repeat (2) cycle();
    s_awvalid = 0; s_wvalid = 1; s_wlast = 1;
    repeat (2) cycle();
    s_wvalid = 0; s_wlast = 0;
    drain_req = 1; s_awvalid = 1;
    #1;
    chk("drain_awready", s_awready, 0);
    chk("drain_awvalid", m_awvalid, 0);
    chk("drain_not_idle", drain_idle, 0);
    cycle();
    s_awvalid = 0; m_bvalid = 1;
    cycle();
    chk("drain_one_b", drain_idle, 0);
    cycle();
    m_bvalid = 0;
    chk("drain_idle_rise", drain_idle, 1);
    cycle();
    drain_req = 0;
    #1;
    chk("drain_release_ready", s_awready, 1);
    chk("drain_release_idle", drain_idle, 0);
    cycle();

    // Beat statistics from a clean start.
    do_reset();
    s_arlen = 7; s_arvalid = 1;
    cycle();
    s_arvalid = 0; m_rvalid = 1;
    for (int b = 0; b < 8; b++) begin
      m_rlast = (b == 7); m_rdata = $urandom;
      cycle();
    end
    m_rvalid = 0; m_rlast = 0;
    s_awlen = 3; s_awvalid = 1;
    cycle();
    s_awvalid = 0; s_wvalid = 1;
    for (int b = 0; b < 4; b++) begin
      s_wlast = (b == 3);
      cycle();
    end
    s_wvalid = 0; s_wlast = 0;
    chk("stats_rd_beats", rd_beats, STATS ? 32'd8 : 32'd0);
    chk("stats_wr_beats", wr_beats, STATS ? 32'd4 : 32'd0);
    m_bvalid = 1;
    cycle();
    m_bvalid = 0;

    // Asynchronous reset with reads in flight, then a stray R last.
    s_arlen = 0; s_arvalid = 1;
    repeat (3) cycle();
    s_arvalid = 0;
    chk("pre_reset_outstanding", rd_outstanding, 3);
    #2;
    do_reset();
    m_rvalid = 1; m_rlast = 1;
    cycle();
    m_rvalid = 0; m_rlast = 0;
    chk("stray_rlast_outstanding", rd_outstanding, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      randomize_payload();
      s_arvalid = 1'($urandom); m_arready = 1'($urandom);
      s_awvalid = 1'($urandom); m_awready = 1'($urandom);
      s_wvalid = 1'($urandom); m_wready = 1'($urandom); s_wlast = 1'($urandom);
      m_rvalid = (mdl_rd > 0) && ($urandom_range(0, 2) == 0); m_rlast = 1'($urandom); s_rready = 1'($urandom);
      m_bvalid = (mdl_wr > 0) && ($urandom_range(0, 2) == 0); s_bready = 1'($urandom);
      drain_req = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
